// File: rtl/egress_port_reader.sv
// Host-side read end of the 4-port switch: one egress FIFO per crossbar output,
// drained one byte per bus read, with STATUS and sticky ERR registers.
//
// Handshake: a byte on result<i> moves into FIFO i on a rising edge where
// res_valid[i] and res_ready[i] are both high. res_ready[i] depends only on
// registered FIFO state and on reset, never on res_valid. A res_valid[i]
// seen while res_ready[i] is low drops the byte and sets ovf[i].
module egress_port_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [2:0]       address,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] result0,
  input  logic [WIDTH-1:0] result1,
  input  logic [WIDTH-1:0] result2,
  input  logic [WIDTH-1:0] result3,
  input  logic [3:0]       res_valid,
  output logic [3:0]       res_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [4][DEPTH];
  logic [WIDTH-1:0] mem_d [4][DEPTH];
  logic [AW-1:0]    wptr_q [4];
  logic [AW-1:0]    wptr_d [4];
  logic [AW-1:0]    rptr_q [4];
  logic [AW-1:0]    rptr_d [4];
  logic [CW-1:0]    count_q [4];
  logic [CW-1:0]    count_d [4];
  logic [3:0]       ovf_q, ovf_d;
  logic [3:0]       udf_q, udf_d;
  logic [WIDTH-1:0] readdata_q, readdata_d;

  logic [WIDTH-1:0] res_data [4];
  logic [3:0]       full;
  logic [3:0]       nempty;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic             rd;
  logic             unused_write;

  // The write strobe has no effect on this block.
  assign unused_write = write;

  assign res_data[0] = result0;
  assign res_data[1] = result1;
  assign res_data[2] = result2;
  assign res_data[3] = result3;

  // Ready is forced low while reset is asserted, otherwise "not full".
  assign res_ready = ~full & {4{~reset}};
  assign readdata  = readdata_q;
  assign rd        = chipselect & read;

  // Full/non-empty flags decoded from registered counts.
  always_comb begin
    full   = '0;
    nempty = '0;
    for (int i = 0; i < 4; i++) begin
      full[i]   = (count_q[i] == FULL_CNT);
      nempty[i] = (count_q[i] != '0);
    end
  end

  // Next-state for FIFOs, sticky errors and the read response register.
  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    readdata_d = readdata_q;
    push       = '0;
    pop        = '0;

    // ERR read clears first so that same-cycle error events below win.
    if (rd && address == 3'b101) begin
      ovf_d = '0;
      udf_d = '0;
    end

    for (int i = 0; i < 4; i++) begin
      push[i] = res_valid[i] & ~full[i];
      if (res_valid[i] && full[i]) ovf_d[i] = 1'b1;
      if (rd && !address[2] && address[1:0] == 2'(i)) begin
        if (nempty[i]) pop[i] = 1'b1;
        else           udf_d[i] = 1'b1;
      end
      if (push[i]) begin
        mem_d[i][wptr_q[i]] = res_data[i];
        wptr_d[i]           = wptr_q[i] + PTR_ONE;
      end
      if (pop[i]) rptr_d[i] = rptr_q[i] + PTR_ONE;
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CNT_ONE;
        2'b01:   count_d[i] = count_q[i] - CNT_ONE;
        default: count_d[i] = count_q[i];
      endcase
    end

    // Read response is taken from state before this cycle's push/pop.
    if (rd) begin
      case (address)
        3'b000, 3'b001, 3'b010, 3'b011: begin
          if (nempty[address[1:0]])
            readdata_d = mem_q[address[1:0]][rptr_q[address[1:0]]];
          else
            readdata_d = '0;
        end
        3'b100:  readdata_d = WIDTH'({full, nempty});
        3'b101:  readdata_d = WIDTH'({udf_q, ovf_q});
        default: readdata_d = '0;
      endcase
    end
  end

  // Control state with synchronous reset; a read in a reset cycle is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
      ovf_q      <= '0;
      udf_q      <= '0;
      readdata_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      readdata_q <= readdata_d;
    end
  end

  // FIFO storage; contents are meaningless until addressed by valid pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_egress_port_reader.sv
// Directed bench for egress_port_reader: a vector table covering the read
// map, FIFO ordering, overflow/underflow and wrap, plus a hand-written
// mid-stream reset sequence.
module tb_egress_port_reader;

  logic       clk;
  logic       reset;
  logic       chipselect;
  logic       read;
  logic       write;
  logic [2:0] address;
  logic [7:0] readdata;
  logic [7:0] result0, result1, result2, result3;
  logic [3:0] res_valid;
  logic [3:0] res_ready;

  int n_cmp;
  int n_err;

  typedef struct {
    logic       rst;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [2:0] addr;
    logic [3:0] vld;
    logic [7:0] din;
    logic [3:0] exp_rdy;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  egress_port_reader #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .readdata   (readdata),
    .result0    (result0),
    .result1    (result1),
    .result2    (result2),
    .result3    (result3),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got 0x%02h expected 0x%02h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle: check res_ready before the edge, readdata after it.
  task automatic step(input int idx, input logic rst, input logic cs, input logic rd,
                      input logic wr, input logic [2:0] a, input logic [3:0] v,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3,
                      input logic [3:0] er, input logic [7:0] ed);
    reset      = rst;
    chipselect = cs;
    read       = rd;
    write      = wr;
    address    = a;
    res_valid  = v;
    result0    = d0;
    result1    = d1;
    result2    = d2;
    result3    = d3;
    #1;
    check8("res_ready", idx, {4'h0, res_ready}, {4'h0, er});
    @(posedge clk);
    #1;
    check8("readdata", idx, readdata, ed);
  endtask

  task automatic add(input logic rst, input logic cs, input logic rd, input logic wr,
                     input logic [2:0] a, input logic [3:0] v, input logic [7:0] d,
                     input logic [3:0] er, input logic [7:0] ed);
    vec_t t;
    t.rst = rst; t.cs = cs; t.rd = rd; t.wr = wr; t.addr = a;
    t.vld = v; t.din = d; t.exp_rdy = er; t.exp_rd = ed;
    vecs.push_back(t);
  endtask

  task automatic add_rd(input logic [2:0] a, input logic [3:0] er, input logic [7:0] ed);
    add(1'b0, 1'b1, 1'b1, 1'b0, a, 4'h0, 8'h00, er, ed);
  endtask

  task automatic add_push(input logic [3:0] v, input logic [7:0] d, input logic [3:0] er, input logic [7:0] ed);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, v, d, er, ed);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0; address = 3'd0;
    res_valid = 4'h0; result0 = '0; result1 = '0; result2 = '0; result3 = '0;

    // Reset, then sweep the register map on empty FIFOs.
    add(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 8'h00, 4'h0, 8'h00);
    add_rd(3'd0, 4'hF, 8'h00);
    add_rd(3'd1, 4'hF, 8'h00);
    add_rd(3'd2, 4'hF, 8'h00);
    add_rd(3'd3, 4'hF, 8'h00);
    add_rd(3'd4, 4'hF, 8'h00);
    add_rd(3'd6, 4'hF, 8'h00);
    add_rd(3'd7, 4'hF, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 4'h0, 8'h00, 4'hF, 8'h00); // write strobe: no clear
    add(1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 4'h0, 8'h00, 4'hF, 8'h00); // read without chipselect
    add_rd(3'd5, 4'hF, 8'hF0);
    add_rd(3'd5, 4'hF, 8'h00);

    // Port 2 ordering and latency.
    add_push(4'h4, 8'h11, 4'hF, 8'h00);
    add_push(4'h4, 8'h22, 4'hF, 8'h00);
    add_push(4'h4, 8'h33, 4'hF, 8'h00);
    add_rd(3'd4, 4'hF, 8'h04);
    add_rd(3'd2, 4'hF, 8'h11);
    add_rd(3'd2, 4'hF, 8'h22);
    add_rd(3'd2, 4'hF, 8'h33);
    add_push(4'h0, 8'h00, 4'hF, 8'h33);

    // Push and pop on the same port in one cycle.
    add_push(4'h4, 8'h66, 4'hF, 8'h33);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 4'h4, 8'h67, 4'hF, 8'h66);
    add_rd(3'd2, 4'hF, 8'h67);
    add_rd(3'd4, 4'hF, 8'h00);

    // Port 1 overflow: six bytes into a four-entry FIFO.
    add_push(4'h2, 8'hA0, 4'hF, 8'h00);
    add_push(4'h2, 8'hA1, 4'hF, 8'h00);
    add_push(4'h2, 8'hA2, 4'hF, 8'h00);
    add_push(4'h2, 8'hA3, 4'hF, 8'h00);
    add_push(4'h2, 8'hA4, 4'hD, 8'h00);
    add_push(4'h2, 8'hA5, 4'hD, 8'h00);
    add_rd(3'd4, 4'hD, 8'h22);
    add_rd(3'd5, 4'hD, 8'h02);
    add_rd(3'd1, 4'hD, 8'hA0);
    add_rd(3'd1, 4'hF, 8'hA1);
    add_rd(3'd1, 4'hF, 8'hA2);
    add_rd(3'd1, 4'hF, 8'hA3);
    add_rd(3'd1, 4'hF, 8'h00);
    add_rd(3'd5, 4'hF, 8'h20);

    // Port 0: full FIFO, pop with a rejected push, then pointer wrap.
    add_push(4'h1, 8'hC0, 4'hF, 8'h20);
    add_push(4'h1, 8'hC1, 4'hF, 8'h20);
    add_push(4'h1, 8'hC2, 4'hF, 8'h20);
    add_push(4'h1, 8'hC3, 4'hF, 8'h20);
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'h1, 8'h5A, 4'hE, 8'hC0);
    add_push(4'h1, 8'h5B, 4'hF, 8'hC0);
    add_rd(3'd0, 4'hE, 8'hC1);
    add_rd(3'd0, 4'hF, 8'hC2);
    add_rd(3'd0, 4'hF, 8'hC3);
    add_rd(3'd0, 4'hF, 8'h5B);
    add_rd(3'd5, 4'hF, 8'h01);

    // Port 3: push into empty FIFO while reading it (no bypass).
    add(1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 4'h8, 8'h77, 4'hF, 8'h00);
    add_rd(3'd3, 4'hF, 8'h77);
    add_rd(3'd5, 4'hF, 8'h80);

    foreach (vecs[k]) begin
      step(k, vecs[k].rst, vecs[k].cs, vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].vld,
           vecs[k].din, vecs[k].din, vecs[k].din, vecs[k].din,
           vecs[k].exp_rdy, vecs[k].exp_rd);
    end

    // Mid-stream reset with a read strobe: queues and stickies discarded.
    step(100, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF, 8'h00);
    step(101, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 8'h40, 8'h41, 8'h42, 8'h43, 4'hF, 8'h00);
    step(102, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 8'h50, 8'h51, 8'h52, 8'h53, 4'hF, 8'h00);
    step(103, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF, 8'h41);
    step(104, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF, 8'h0F);
    step(105, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'hF, 8'h60, 8'h61, 8'h62, 8'h63, 4'h0, 8'h00);
    step(106, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF, 8'h00);
    step(107, 1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF, 8'h00);
    step(108, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
